// File: rtl/int_arb_pkg.sv
// int_arb_pkg
// Shared definitions for the interrupt arbiter:
//   arb_state_t  - FSM state encoding
//   DEF_*        - default sizing used by int_arbiter
//   lvl_none()   - background level code for a given number of IRQ lines
package int_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_PUSH = 3'd2,
    ST_GAP  = 3'd3,
    ST_POP  = 3'd4,
    ST_DONE = 3'd5
  } arb_state_t;

  localparam int unsigned DEF_NUM_IRQ     = 4;
  localparam int unsigned DEF_ADDR_WIDTH  = 16;
  localparam int unsigned DEF_STACK_DEPTH = 8;
  localparam int unsigned DEF_TIMEOUT     = 64;

  // Level codes 0..NUM_IRQ-1 are IRQ priorities; NUM_IRQ means no ISR running.
  function automatic int unsigned lvl_none(input int unsigned num_irq);
    return num_irq;
  endfunction

endpackage

// File: rtl/int_lvl_stack.sv
// int_lvl_stack
// LIFO of saved priority levels, one entry per nesting level.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (empties the stack)
//   push, din     store din on top (ignored when full)
//   pop           discard top entry (ignored when empty)
//   top_lvl       current top entry (0 when empty)
//   count         number of stored entries
//   full, empty   occupancy flags
module int_lvl_stack
  import int_arb_pkg::*;
#(
  parameter int unsigned LVL_W = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LVL_W-1:0] din,
  output logic [LVL_W-1:0] top_lvl,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LVL_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full   = (ptr == CNT_W'(DEPTH));
  assign empty  = (ptr == '0);
  assign wr_idx = AW'(ptr);
  assign rd_idx = AW'(ptr - 1'b1);
  assign count  = ptr;
  assign top_lvl = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  // Entries above the pointer are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// int_arbiter
// Interrupt scheduler between the IRQ lines, AP_ctrl and the context stack.
// Latches IRQ rising edges, offers the highest-priority unmasked request that
// outranks the running level, strobes the context stack on accept/return and
// restores the previous level after a return.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   irq, irq_mask     request lines (edge detected), per-line disable
//   int_req, int_vec  offer to AP_ctrl and its vector
//   int_ack           AP_ctrl takes the offer
//   ret_req           AP_ctrl return-from-interrupt pulse
//   int_set           push strobe to context stack
//   ret_valid         pop strobe to context stack, held until ctxt_rdy
//   ctxt_rdy          context stack finished restoring
//   resume            one-cycle pulse, AP_ctrl may resume
//   depth, cur_lvl    nesting depth, running level (NUM_IRQ = background)
//   overflow_err, underflow_err, ret_timeout_err   sticky error flags
// Build option: define INT_ARB_TIMEOUT_EN to abort a return after
// TIMEOUT_CYCLES cycles without ctxt_rdy; otherwise ret_timeout_err is 0.
//
// state | meaning
// IDLE  | waiting for a return or an eligible request
// REQ   | int_req offered with latched vector, waiting for int_ack / ret_req
// PUSH  | int_set pulse, level pushed, cur_lvl takes the new level
// GAP   | int_set low for one cycle before any further push
// POP   | ret_valid held until ctxt_rdy
// DONE  | resume pulse, level restored
module int_arbiter
  import int_arb_pkg::*;
#(
  parameter int unsigned NUM_IRQ        = DEF_NUM_IRQ,
  parameter int unsigned ADDR_WIDTH_MEM = DEF_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter logic [ADDR_WIDTH_MEM-1:0] VEC_BASE   = 16'h0100,
  parameter logic [ADDR_WIDTH_MEM-1:0] VEC_STRIDE = 16'h0010,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_IRQ-1:0]                 irq,
  input  logic [NUM_IRQ-1:0]                 irq_mask,
  output logic                               int_req,
  output logic [ADDR_WIDTH_MEM-1:0]          int_vec,
  input  logic                               int_ack,
  input  logic                               ret_req,
  output logic                               int_set,
  output logic                               ret_valid,
  input  logic                               ctxt_rdy,
  output logic                               resume,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic [$clog2(NUM_IRQ+1)-1:0]       cur_lvl,
  output logic                               overflow_err,
  output logic                               underflow_err,
  output logic                               ret_timeout_err
);

  localparam int unsigned LVL_W = $clog2(NUM_IRQ + 1);
  localparam logic [LVL_W-1:0] LVL_NONE = LVL_W'(lvl_none(NUM_IRQ));

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("int_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t         state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [LVL_W-1:0]   k_lat;

  logic               win_valid;
  logic [LVL_W-1:0]   win_idx;
  logic [ADDR_WIDTH_MEM-1:0] win_vec;
  logic               outranks;
  logic               eligible;
  logic               ovf_hit;

  logic               stk_push;
  logic               stk_pop;
  logic [LVL_W-1:0]   stk_top;
  logic               stk_full;
  logic               stk_empty;

  assign irq_rise = irq & ~irq_q;
  assign pend_clr = (state == ST_PUSH) ? (NUM_IRQ'(1) << k_lat) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq;
      // A fresh edge on the line being pushed must not be lost.
      pend  <= (pend & ~pend_clr) | irq_rise;
    end
  end

  // Lowest index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i] && !irq_mask[i]) begin
        win_valid = 1'b1;
        win_idx   = LVL_W'(i);
      end
    end
  end

  assign win_vec  = VEC_BASE + VEC_STRIDE * ADDR_WIDTH_MEM'(win_idx);
  assign outranks = win_valid && (win_idx < cur_lvl);
  assign eligible = outranks && !stk_full;
  assign ovf_hit  = outranks && stk_full;

  assign stk_push = (state == ST_PUSH);
  assign stk_pop  = (state == ST_POP) && ctxt_rdy;

  int_lvl_stack #(
    .LVL_W (LVL_W),
    .DEPTH (STACK_DEPTH)
  ) u_lvl_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (cur_lvl),
    .top_lvl (stk_top),
    .count   (depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

`ifdef INT_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign ret_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      k_lat         <= '0;
      cur_lvl       <= LVL_NONE;
      int_req       <= 1'b0;
      int_vec       <= '0;
      int_set       <= 1'b0;
      ret_valid     <= 1'b0;
      resume        <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
`ifdef INT_ARB_TIMEOUT_EN
      to_cnt          <= '0;
      ret_timeout_err <= 1'b0;
`endif
    end else begin
      int_set <= 1'b0;
      resume  <= 1'b0;
      if (ovf_hit) begin
        overflow_err <= 1'b1;
      end
`ifdef INT_ARB_TIMEOUT_EN
      // Down-counter is parked at its load value outside POP.
      if (state != ST_POP) begin
        to_cnt <= TO_LOAD;
      end
`endif
      case (state)
        ST_IDLE: begin
          if (ret_req) begin
            if (stk_empty) begin
              underflow_err <= 1'b1;
            end else begin
              ret_valid <= 1'b1;
              state     <= ST_POP;
            end
          end else if (eligible) begin
            k_lat   <= win_idx;
            int_vec <= win_vec;
            int_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A return takes precedence so a withdrawn offer stays pending.
          if (ret_req) begin
            int_req <= 1'b0;
            int_vec <= '0;
            if (stk_empty) begin
              underflow_err <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              ret_valid <= 1'b1;
              state     <= ST_POP;
            end
          end else if (int_ack) begin
            int_req <= 1'b0;
            int_vec <= '0;
            int_set <= 1'b1;
            state   <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          cur_lvl <= k_lat;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        ST_POP: begin
          if (ctxt_rdy) begin
            ret_valid <= 1'b0;
            resume    <= 1'b1;
            cur_lvl   <= stk_top;
            state     <= ST_DONE;
          end
`ifdef INT_ARB_TIMEOUT_EN
          else if (to_cnt == '0) begin
            ret_valid       <= 1'b0;
            ret_timeout_err <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          int_req   <= 1'b0;
          ret_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
module tb_int_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  irq, irq_mask;
  logic        int_req, int_ack, ret_req, int_set, ret_valid, ctxt_rdy, resume;
  logic [15:0] int_vec;
  logic [3:0]  depth;
  logic [2:0]  cur_lvl;
  logic        overflow_err, underflow_err, ret_timeout_err;

  logic [8:0]  irq_b, irq_mask_b;
  logic        int_req_b, int_ack_b, ret_req_b, int_set_b, ret_valid_b, ctxt_rdy_b, resume_b;
  logic [15:0] int_vec_b;
  logic [3:0]  depth_b;
  logic [3:0]  cur_lvl_b;
  logic        overflow_err_b, underflow_err_b, ret_timeout_err_b;

  int n_cmp = 0;
  int n_mis = 0;
  int n;

  int_arbiter dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask),
    .int_req(int_req), .int_vec(int_vec), .int_ack(int_ack), .ret_req(ret_req),
    .int_set(int_set), .ret_valid(ret_valid), .ctxt_rdy(ctxt_rdy), .resume(resume),
    .depth(depth), .cur_lvl(cur_lvl), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .ret_timeout_err(ret_timeout_err)
  );

  // Nine lines so that eight strictly rising priorities can fill the stack.
  int_arbiter #(.NUM_IRQ(9)) dut_ovf (
    .clk(clk), .rst(rst), .irq(irq_b), .irq_mask(irq_mask_b),
    .int_req(int_req_b), .int_vec(int_vec_b), .int_ack(int_ack_b), .ret_req(ret_req_b),
    .int_set(int_set_b), .ret_valid(ret_valid_b), .ctxt_rdy(ctxt_rdy_b), .resume(resume_b),
    .depth(depth_b), .cur_lvl(cur_lvl_b), .overflow_err(overflow_err_b),
    .underflow_err(underflow_err_b), .ret_timeout_err(ret_timeout_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    irq = '0; irq_mask = '0; int_ack = 0; ret_req = 0; ctxt_rdy = 0;
    irq_b = '0; irq_mask_b = '0; int_ack_b = 0; ret_req_b = 0; ctxt_rdy_b = 0;
    step(); step();
    check_val("rst_int_req",   32'(int_req), 0);
    check_val("rst_int_set",   32'(int_set), 0);
    check_val("rst_ret_valid", 32'(ret_valid), 0);
    check_val("rst_resume",    32'(resume), 0);
    check_val("rst_depth",     32'(depth), 0);
    check_val("rst_cur_lvl",   32'(cur_lvl), 4);
    check_val("rst_errs",      32'({overflow_err, underflow_err, ret_timeout_err}), 0);
    check_val("rst_cur_lvl_b", 32'(cur_lvl_b), 9);
    rst = 1'b1;
    step();

    // IRQ2 accepted from background
    irq = 4'b0100;
    step();
    check_val("t1_no_req_yet", 32'(int_req), 0);
    step();
    check_val("t1_req", 32'(int_req), 1);
    check_val("t1_vec", 32'(int_vec), 32'h0120);
    step();
    check_val("t1_req_held", 32'(int_req), 1);
    int_ack = 1;
    step();
    int_ack = 0;
    check_val("t1_int_set", 32'(int_set), 1);
    check_val("t1_depth_in_push", 32'(depth), 0);
    step();
    check_val("t1_int_set_off", 32'(int_set), 0);
    check_val("t1_depth", 32'(depth), 1);
    check_val("t1_cur_lvl", 32'(cur_lvl), 2);
    step();

    // IRQ3 cannot preempt IRQ2; IRQ0 can
    irq = 4'b1100;
    step(); step(); step();
    check_val("t2_irq3_blocked", 32'(int_req), 0);
    irq = 4'b1101;
    step(); step();
    check_val("t2_req0", 32'(int_req), 1);
    check_val("t2_vec0", 32'(int_vec), 32'h0100);
    int_ack = 1;
    step();
    int_ack = 0;
    check_val("t2_int_set", 32'(int_set), 1);
    step();
    check_val("t2_depth", 32'(depth), 2);
    check_val("t2_cur_lvl", 32'(cur_lvl), 0);
    step();
    irq = '0;

    // Return with ctxt_rdy arriving in the third POP cycle
    ret_req = 1;
    step();
    ret_req = 0;
    check_val("t3_rv_c1", 32'(ret_valid), 1);
    step();
    check_val("t3_rv_c2", 32'(ret_valid), 1);
    step();
    check_val("t3_rv_c3", 32'(ret_valid), 1);
    ctxt_rdy = 1;
    step();
    ctxt_rdy = 0;
    check_val("t3_resume", 32'(resume), 1);
    check_val("t3_rv_off", 32'(ret_valid), 0);
    check_val("t3_cur_lvl", 32'(cur_lvl), 2);
    check_val("t3_depth", 32'(depth), 1);
    step();
    check_val("t3_resume_off", 32'(resume), 0);
    step();
    check_val("t3_irq3_still_blocked", 32'(int_req), 0);
    ret_req = 1;
    step();
    ret_req = 0;
    ctxt_rdy = 1;
    step();
    ctxt_rdy = 0;
    check_val("t3_cur_lvl_bg", 32'(cur_lvl), 4);
    check_val("t3_depth0", 32'(depth), 0);
    step();
    step();
    check_val("t3_req3", 32'(int_req), 1);
    check_val("t3_vec3", 32'(int_vec), 32'h0130);
    int_ack = 1;
    step();
    int_ack = 0;
    step();
    check_val("t3_depth_irq3", 32'(depth), 1);
    check_val("t3_cur_lvl3", 32'(cur_lvl), 3);
    step();

    // Return with ctxt_rdy held low
    ret_req = 1;
    step();
    ret_req = 0;
    n = 0;
    while (ret_valid && n < 100) begin
      n++;
      step();
    end
`ifdef INT_ARB_TIMEOUT_EN
    check_val("to_len", 32'(n), 64);
    check_val("to_err", 32'(ret_timeout_err), 1);
    check_val("to_no_resume", 32'(resume), 0);
    check_val("to_depth", 32'(depth), 1);
    check_val("to_cur_lvl", 32'(cur_lvl), 3);
    ret_req = 1;
    step();
    ret_req = 0;
`else
    check_val("hold_len", 32'(n), 100);
    check_val("hold_no_to_err", 32'(ret_timeout_err), 0);
`endif
    ctxt_rdy = 1;
    step();
    ctxt_rdy = 0;
    check_val("t5_resume", 32'(resume), 1);
    check_val("t5_depth", 32'(depth), 0);
    check_val("t5_cur_lvl", 32'(cur_lvl), 4);
    step();

    // Underflow
    check_val("t6_unf_pre", 32'(underflow_err), 0);
    ret_req = 1;
    step();
    ret_req = 0;
    check_val("t6_no_rv", 32'(ret_valid), 0);
    check_val("t6_unf", 32'(underflow_err), 1);
    step();
    check_val("t6_no_rv2", 32'(ret_valid), 0);

    // Masked line keeps its pending bit
    irq_mask = 4'b0010;
    irq = 4'b0010;
    step(); step(); step();
    check_val("t7_masked", 32'(int_req), 0);
    irq_mask = 4'b0000;
    step();
    check_val("t7_unmasked_req", 32'(int_req), 1);
    check_val("t7_vec1", 32'(int_vec), 32'h0110);
    int_ack = 1;
    step();
    int_ack = 0;
    step();
    check_val("t7_cur_lvl1", 32'(cur_lvl), 1);
    step();

    // ret_req beats a simultaneous eligible request
    irq = 4'b0011;
    step();
    ret_req = 1;
    step();
    ret_req = 0;
    check_val("t8_ret_first_rv", 32'(ret_valid), 1);
    check_val("t8_ret_first_req", 32'(int_req), 0);
    ctxt_rdy = 1;
    step();
    ctxt_rdy = 0;
    check_val("t8_cur_lvl", 32'(cur_lvl), 4);
    step(); step();
    check_val("t8_req0", 32'(int_req), 1);
    check_val("t8_vec0", 32'(int_vec), 32'h0100);

    // Asynchronous reset mid-offer
    rst = 1'b0;
    #2;
    check_val("t9_async_req", 32'(int_req), 0);
    check_val("t9_async_lvl", 32'(cur_lvl), 4);
    irq = '0;
    step();
    rst = 1'b1;
    step(); step(); step();
    check_val("t9_pending_lost", 32'(int_req), 0);
    check_val("t9_unf_cleared", 32'(underflow_err), 0);

    // Overflow on the nine-line instance: fill 8 levels with IRQ8..IRQ1
    for (int k = 8; k >= 1; k--) begin
      irq_b[k] = 1'b1;
      step(); step();
      check_val($sformatf("ovf_fill_req%0d", k), 32'(int_req_b), 1);
      check_val($sformatf("ovf_fill_vec%0d", k), 32'(int_vec_b), 32'h0100 + 32'(k) * 32'h10);
      int_ack_b = 1;
      step();
      int_ack_b = 0;
      step(); step();
    end
    check_val("ovf_depth8", 32'(depth_b), 8);
    check_val("ovf_cur_lvl1", 32'(cur_lvl_b), 1);
    check_val("ovf_pre", 32'(overflow_err_b), 0);
    irq_b[0] = 1'b1;
    step(); step();
    check_val("ovf_flag", 32'(overflow_err_b), 1);
    check_val("ovf_no_req", 32'(int_req_b), 0);
    step(); step();
    check_val("ovf_no_req2", 32'(int_req_b), 0);
    ret_req_b = 1;
    step();
    ret_req_b = 0;
    ctxt_rdy_b = 1;
    step();
    ctxt_rdy_b = 0;
    check_val("ovf_ret_depth", 32'(depth_b), 7);
    check_val("ovf_ret_lvl", 32'(cur_lvl_b), 2);
    step(); step();
    check_val("ovf_reoffer", 32'(int_req_b), 1);
    check_val("ovf_reoffer_vec", 32'(int_vec_b), 32'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
